// File: rtl/cosine_sim_pkg.sv
// cosine_sim_pkg: shared scheduler state encoding, engine latency helper and defaults.
package cosine_sim_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_BUSY    = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } sched_state_t;
  localparam int DEF_TIMEOUT = 64;
  function automatic int ENG_LATENCY(input int w);
    return 3 * w + 4;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first pending request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;
  // requests at or above ptr take priority; otherwise wrap to the lowest set bit
  assign w_hi  = req & ~((NREQ'(1) << ptr) - NREQ'(1));
  assign w_sel = |w_hi ? w_hi : req;
  assign gnt   = w_sel & (~w_sel + NREQ'(1));
endmodule

// File: rtl/cosine_sim_sched.sv
// cosine_sim_sched: round-robin sharing of one cosine_sim engine, with timeout recovery.
module cosine_sim_sched
  import cosine_sim_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 5,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][W-1:0][31:0]   req_vec_a,
  input  logic [NREQ-1:0][W-1:0][31:0]   req_vec_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [$clog2(NREQ)-1:0]        resp_id,
  output logic [31:0]                    resp_data,
  output logic                           resp_err,
  output logic                           eng_start,
  output logic                           eng_rst_n,
  output logic [W-1:0][31:0]             eng_vec_a,
  output logic [W-1:0][31:0]             eng_vec_b,
  input  logic                           eng_valid,
  input  logic [31:0]                    eng_similarity,
  output logic                           busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  sched_state_t r_state, w_next;
  logic [NREQ-1:0]    w_gnt;
  logic [IW-1:0]      w_gid;
  logic [IW-1:0]      r_gid;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic               r_rec;
  logic               r_rst_ok;
  logic [31:0]        r_data;
  logic               r_err;
  logic [W-1:0][31:0] r_vec_a;
  logic [W-1:0][31:0] r_vec_b;
  logic               w_accept;
  logic               w_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(r_ptr),
    .gnt(w_gnt)
  );

  always_comb begin
    w_gid = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) w_gid = IW'(i);
  end

  assign w_accept  = (r_state == S_IDLE) && |req_valid && !rst;
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = |req_valid ? S_START : S_IDLE;
      S_START:   w_next = S_BUSY;
      S_BUSY:    w_next = eng_valid ? S_RESP : w_timeout ? S_RECOVER : S_BUSY;
      S_RECOVER: w_next = r_rec ? S_RESP : S_RECOVER;
      S_RESP:    w_next = resp_ready ? S_IDLE : S_RESP;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_rec   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_vec_a <= '0;
      r_vec_b <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_BUSY) ? r_cnt + 1'b1 : '0;
      r_rec   <= (r_state == S_RECOVER) && !r_rec;
      if (w_accept) begin
        r_gid   <= w_gid;
        r_vec_a <= req_vec_a[w_gid];
        r_vec_b <= req_vec_b[w_gid];
      end
      if (r_state == S_BUSY && eng_valid) begin
        r_data <= eng_similarity;
        r_err  <= 1'b0;
      end
      if (r_state == S_RECOVER) begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
      if (r_state == S_RESP && resp_ready)
        r_ptr <= (r_gid == IW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
    end
  end

  // engine reset stays asserted for the first cycle after rst releases
  always_ff @(posedge clk) r_rst_ok <= !rst;

  assign req_ready  = w_accept ? w_gnt : '0;
  assign eng_start  = r_state == S_START;
  assign eng_rst_n  = r_rst_ok && !rst && (r_state != S_RECOVER);
  assign resp_valid = r_state == S_RESP;
  assign resp_id    = r_gid;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign eng_vec_a  = r_vec_a;
  assign eng_vec_b  = r_vec_b;
  assign busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_cosine_sim_sched.sv
// tb_cosine_sim_sched: table-driven and randomized checks of the shared-engine scheduler.
module tb_cosine_sim_sched;
  import cosine_sim_pkg::*;
  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int T    = DEF_TIMEOUT;
  localparam int NOM  = ENG_LATENCY(W);
  typedef logic [W-1:0][31:0] vec_t;
  typedef struct {
    logic [3:0]  mask;
    int          id;
    int          delay;
    int          hold;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0][W-1:0][31:0] req_vec_a = '0;
  logic [NREQ-1:0][W-1:0][31:0] req_vec_b = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [1:0] resp_id;
  logic [31:0] resp_data;
  logic resp_err;
  logic eng_start;
  logic eng_rst_n;
  vec_t eng_vec_a;
  vec_t eng_vec_b;
  logic eng_valid = 1'b0;
  logic [31:0] eng_similarity = '0;
  logic busy;

  int checks = 0;
  int errors = 0;
  int eng_delay = NOM;
  int eng_cnt = -1;

  cosine_sim_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .eng_start(eng_start), .eng_rst_n(eng_rst_n),
    .eng_vec_a(eng_vec_a), .eng_vec_b(eng_vec_b),
    .eng_valid(eng_valid), .eng_similarity(eng_similarity),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in engine: 1.0 for identical vectors, otherwise a fold of the inputs
  function automatic logic [31:0] engine_fn(input vec_t a, input vec_t b);
    logic [31:0] r;
    if (a == b) return 32'h3F80_0000;
    r = 32'h3E00_0000;
    for (int k = 0; k < W; k++) r = {r[30:0], r[31]} ^ a[k] ^ {b[k][15:0], b[k][31:16]};
    return r;
  endfunction

  // result appears eng_delay cycles after the start cycle; eng_delay < 0 means hang
  always @(negedge clk) begin
    eng_valid = 1'b0;
    if (!eng_rst_n) eng_cnt = -1;
    else if (eng_start) eng_cnt = eng_delay;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_valid = 1'b1;
        eng_similarity = engine_fn(eng_vec_a, eng_vec_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rand_vecs;
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < W; k++) begin
        req_vec_a[r][k] = $urandom;
        req_vec_b[r][k] = $urandom;
      end
  endtask

  task automatic run_job(input logic [3:0] mask, input int exp_id, input int delay,
                         input int hold, input logic [31:0] exp_data, input bit scramble);
    int n = 0, starts = 0, rstlow = 0, lat;
    bit err, vstable = 1, nordy = 1, hstable = 1;
    vec_t sa, sb;
    err = delay < 0 || delay > T;
    lat = err ? T + 4 : delay + 2;
    eng_delay = delay;
    chk("idle_before_accept", 32'(busy), 32'd0);
    req_valid = mask;
    resp_ready = (hold == 0);
    #1;
    chk("grant", 32'(req_ready), 32'(4'(1) << exp_id));
    sa = req_vec_a[exp_id];
    sb = req_vec_b[exp_id];
    while (!resp_valid && n < T + 20) begin
      @(negedge clk);
      n++;
      starts += 32'(eng_start);
      rstlow += 32'(!eng_rst_n);
      if (req_ready != '0) nordy = 0;
      if (eng_vec_a !== sa || eng_vec_b !== sb) vstable = 0;
      if (scramble) rand_vecs();
    end
    chk("latency", 32'(n), 32'(lat));
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_data", resp_data, err ? 32'd0 : exp_data);
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("eng_start_count", 32'(starts), 32'd1);
    chk("eng_rst_low_cycles", 32'(rstlow), err ? 32'd2 : 32'd0);
    repeat (hold) begin
      @(negedge clk);
      if (!resp_valid || resp_id !== 2'(exp_id) || resp_err !== err || req_ready != '0 ||
          eng_start || !busy || resp_data !== (err ? 32'd0 : exp_data)) hstable = 0;
      if (eng_vec_a !== sa || eng_vec_b !== sb) vstable = 0;
      if (scramble) rand_vecs();
    end
    if (hold > 0) chk("backpressure_stable", 32'(hstable), 32'd1);
    chk("no_ready_while_busy", 32'(nordy), 32'd1);
    chk("vectors_stable", 32'(vstable), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = '0;
    chk("handshake_done", 32'(resp_valid), 32'd0);
    chk("idle_after_handshake", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rec_t tbl[16];
    int ptr, id, d, n;
    logic [3:0] mask;
    logic [31:0] fone [W] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

    rand_vecs();
    for (int k = 0; k < W; k++) begin
      req_vec_a[2][k] = fone[k];
      req_vec_b[2][k] = fone[k];
    end
    tbl[0]  = '{4'b1111, 0, NOM, 0, '0};
    tbl[1]  = '{4'b1111, 1, NOM, 0, '0};
    tbl[2]  = '{4'b1111, 2, NOM, 0, '0};
    tbl[3]  = '{4'b1111, 3, NOM, 1, '0};
    tbl[4]  = '{4'b1111, 0, NOM, 0, '0};
    tbl[5]  = '{4'b1111, 1, NOM, 2, '0};
    tbl[6]  = '{4'b1111, 2, NOM, 0, '0};
    tbl[7]  = '{4'b1111, 3, NOM, 0, '0};
    tbl[8]  = '{4'b0100, 2, NOM, 0, '0};
    tbl[9]  = '{4'b0011, 0, NOM, 10, '0};
    tbl[10] = '{4'b1001, 3, -1, 3, '0};
    tbl[11] = '{4'b1000, 3, NOM, 0, '0};
    tbl[12] = '{4'b0110, 1, T, 0, '0};
    tbl[13] = '{4'b1011, 3, 7, 0, '0};
    tbl[14] = '{4'b0011, 0, 1, 1, '0};
    tbl[15] = '{4'b0110, 1, NOM, 0, '0};
    for (int i = 0; i < 16; i++) tbl[i].data = engine_fn(req_vec_a[tbl[i].id], req_vec_b[tbl[i].id]);
    tbl[8].data = 32'h3F80_0000;

    // reset state, with requests pending while rst is high
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_eng_vec_a", eng_vec_a[0], 32'd0);
    req_valid = '0;
    rst = 1'b0;
    #1 chk("eng_rst_n_first_cycle", 32'(eng_rst_n), 32'd0);
    @(negedge clk);
    chk("eng_rst_n_release", 32'(eng_rst_n), 32'd1);

    for (int i = 0; i < 16; i++)
      run_job(tbl[i].mask, tbl[i].id, tbl[i].delay, tbl[i].hold, tbl[i].data, 1'b0);

    // reset during BUSY drops the job and clears the pointer
    eng_delay = NOM;
    req_valid = 4'b0010;
    #1 chk("abort_grant", 32'(req_ready), 32'b0010);
    repeat (6) @(negedge clk);
    chk("abort_in_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_id", 32'(resp_id), 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
    chk("mid_rst_eng_start", 32'(eng_start), 32'd0);
    chk("mid_rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    chk("mid_rst_eng_vec_b", eng_vec_b[W-1], 32'd0);
    rst = 1'b0;
    #1 chk("mid_rst_eng_rst_n_hold", 32'(eng_rst_n), 32'd0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += 32'(resp_valid);
    end
    chk("aborted_no_response", 32'(n), 32'd0);
    run_job(4'b1111, 0, NOM, 0, engine_fn(req_vec_a[0], req_vec_b[0]), 1'b0);
    ptr = 1;

    // randomized jobs against the round-robin reference
    for (int j = 0; j < 40; j++) begin
      mask = 4'($urandom_range(1, 15));
      id = -1;
      for (int i = 0; i < NREQ && id < 0; i++)
        if (mask[(ptr + i) % NREQ]) id = (ptr + i) % NREQ;
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, T + 4));
      rand_vecs();
      run_job(mask, id, d, int'($urandom_range(0, 3)), engine_fn(req_vec_a[id], req_vec_b[id]), 1'b1);
      ptr = (id + 1) % NREQ;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cosine_sim_sched.md
# cosine_sim_sched

Round-robin scheduler that shares one `cosine_sim` engine between `NREQ` requesters. It arbitrates among pending jobs and latches the winner's vector pair into holding registers. It drives the engine start pulse and returns the result to the winning requester over a valid/ready response channel tagged with the requester ID. A timeout watchdog resets a hung engine and returns an error response, so the requester is never left waiting.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `W`, 5: vector length; must equal the engine's `W`.
- `TIMEOUT`, 64: maximum cycles in BUSY before abort; must exceed 3W+4.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester job pending.
- `req_ready` out NREQ: one-hot accept strobe.
- `req_vec_a` in NREQ×W×32: per-requester vector A (IEEE-754 single).
- `req_vec_b` in NREQ×W×32: per-requester vector B.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts result.
- `resp_id` out $clog2(NREQ): requester index of the result.
- `resp_data` out 32: similarity (float).
- `resp_err` out 1: job aborted by timeout; `resp_data` is 0.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_rst_n` out 1: active-low engine reset.
- `eng_vec_a` out W×32: held vector A to the engine.
- `eng_vec_b` out W×32: held vector B to the engine.
- `eng_valid` in 1: engine done pulse.
- `eng_similarity` in 32: engine result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, BUSY, RESP, RECOVER.
- **IDLE:**
  - If any `req_valid`, the round-robin arbiter picks the first set bit at or after pointer `rr_ptr`, wrapping modulo NREQ.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - The winner's vectors and `g` are latched; next state is START.
- **START:** `eng_start`=1 for exactly this cycle; next state BUSY; watchdog counter cleared.
- **BUSY:**
  - Counter increments each cycle.
  - On `eng_valid`: latch `eng_similarity`, set `resp_err`=0, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: go to RECOVER.
- **RECOVER:**
  - `eng_rst_n`=0 for 2 cycles.
  - `resp_data`=0, `resp_err`=1, then go to RESP.
- **RESP:**
  - `resp_valid`=1; `resp_id`, `resp_data` and `resp_err` stay stable until `resp_ready`.
  - On handshake: `rr_ptr` ← (g+1) mod NREQ, next state IDLE.
- `eng_vec_a`/`eng_vec_b` change only on the IDLE acceptance cycle. They are stable from START through RESP, because the engine reads them over many cycles.
- `eng_valid` seen outside BUSY is ignored.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `eng_start`=0, `busy`=0, holding registers 0.
- `eng_rst_n`=0 while `rst` is high and during the cycle after `rst` falls. This puts the engine in IDLE before the first job.
- Latency:
  - Accept cycle t → `eng_start` at t+1.
  - Engine nominal 3W+4 cycles.
  - `resp_valid` rises the cycle after `eng_valid`.
  - With W=5: `resp_valid` at t+21 if the consumer is ready.
- Throughput: one job in flight. A new job is accepted no earlier than the cycle after the RESP handshake (one IDLE cycle minimum).
- Simultaneous events:
  - `resp_ready` high on the first `resp_valid` cycle completes the handshake in that cycle.
  - `eng_valid` arriving on the timeout cycle wins, so no error is reported.
  - Multiple `req_valid` are resolved by `rr_ptr` only.
  - A requester dropping `req_valid` before it is granted is legal; it is simply not selected.
- `rst` mid-job: all state is cleared, the in-flight job is discarded with no response, and the engine is reset.

## Structure
- Package `cosine_sim_pkg` holds:
  - the `sched_state_t` enum (3-bit, values above);
  - `ENG_LATENCY(W)` = 3W+4 as a localparam function;
  - the default TIMEOUT.
- Sub-module `rr_arbiter #(NREQ)`: combinational one-hot grant from `req` and `rr_ptr`. The pointer register stays in the scheduler.

## Test plan
- **Single request:** NREQ=4, req 2 with A=B=[1,2,3,4,5] → `resp_id`=2, `resp_data`=0x3F800000, `resp_err`=0. `resp_valid` exactly 21 cycles after accept, with a behavioural engine model.
- **Fairness:** all 4 `req_valid` held high for 8 jobs → grant order 0,1,2,3,0,1,2,3. Exactly one `eng_start` per job. Vectors stable through each BUSY.
- **Backpressure:** `resp_ready` low for 10 cycles → outputs stable, no new `req_ready`, no `eng_start`. Handshake on the cycle `resp_ready` rises, then IDLE the next cycle.
- **Timeout:** engine model never asserts `eng_valid` → RECOVER at cycle TIMEOUT-1 of BUSY, `eng_rst_n` low for 2 cycles, then `resp_err`=1 and `resp_data`=0. The next job completes normally.
- **Reset mid-job:** `rst` pulsed during BUSY → all outputs at reset values the next cycle, no response for the aborted job, `rr_ptr`=0.
- **Race:** `eng_valid` on the timeout cycle → normal result, `resp_err`=0.
